irrigation_ctrl_multi: RTL



---
 rtl/irrigation_ctrl_multi_if.sv | 30 +++
 rtl/irrigation_ctrl_multi.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_ctrl_multi_if.sv
// Sensor/actuator bundle of the multi-level irrigation controller.
// master = sensor/display side (drives raw sensors, reads actuators),
// slave  = irrigation_ctrl_multi itself.
interface irrigation_ctrl_multi_if #(
  parameter int LEVELS = 3
);
  localparam int LC_W = $clog2(LEVELS + 1);

  logic [LEVELS-1:0] level;
  logic              Us;
  logic              Ua;
  logic              T;
  logic              Ve;
  logic              Bs;
  logic              Vs;
  logic              Al;
  logic              E;
  logic              working;
  logic [LC_W-1:0]   level_count;

  modport master (
    output level, Us, Ua, T,
    input  Ve, Bs, Vs, Al, E, working, level_count
  );

  modport slave (
    input  level, Us, Ua, T,
    output Ve, Bs, Vs, Al, E, working, level_count
  );
endinterface

// File: rtl/irrigation_ctrl_multi.sv
// Multi-level irrigation controller.
// Debounces LEVELS thermometer tank sensors plus the Us/Ua/T sensors, decodes
// the tank level, and drives the inlet valve (hysteresis FSM), the sprinkler
// pump / drip valve (minimum on-time, break-before-make FSM), the alarm and
// the measurement-error flag. Every output is a register fed from the
// filtered sensor values.
// Optional build macro: ALARM_BLINK_EN -- a low-level alarm (without E)
// blinks with a half-period of BLINK_DIV cycles instead of staying steady.
module irrigation_ctrl_multi #(
  parameter int LEVELS        = 3,
  parameter int DEBOUNCE      = 4,
  parameter int MIN_ON        = 8,
  parameter int FILL_LO       = 2,
  parameter int SPR_MIN_LEVEL = 2,
  parameter int ALARM_LEVEL   = 1
`ifdef ALARM_BLINK_EN
  ,
  parameter int BLINK_DIV     = 16
`endif
) (
  input logic                    clock,
  input logic                    reset,
  irrigation_ctrl_multi_if.slave bus
);

  localparam int LC_W = $clog2(LEVELS + 1);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int TM_W = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
  localparam int NIN  = LEVELS + 3;

  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE);
  localparam logic [TM_W-1:0] TMR_MAX  = TM_W'(MIN_ON - 1);
  // Filtered reset image: tank empty, soil saturated/moist, weather cool.
  localparam logic [NIN-1:0]  FILT_RST = {{LEVELS{1'b0}}, 3'b110};

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_FILL,
    IN_FAULT
  } inlet_t;

  typedef enum logic [1:0] {
    IR_OFF,
    IR_SPRINKLE,
    IR_DRIP,
    IR_GAP
  } irr_t;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  function automatic logic is_thermo(input logic [LEVELS-1:0] v);
    logic ok;
    logic seen_zero;
    ok        = 1'b1;
    seen_zero = 1'b0;
    for (int i = 0; i < LEVELS; i++) begin
      if (!v[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic [LC_W-1:0] popcount(input logic [LEVELS-1:0] v);
    logic [LC_W-1:0] n;
    n = '0;
    for (int i = 0; i < LEVELS; i++) begin
      n = n + LC_W'(v[i]);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic [NIN-1:0]  raw;
  logic [NIN-1:0]  filt_q, filt_d;
  logic [DB_W-1:0] cnt_q [NIN];
  logic [DB_W-1:0] cnt_d [NIN];

  logic [LEVELS-1:0] lvl_f;
  logic              us_f, ua_f, t_f;

  logic              valid_c;
  logic              e_c;
  logic [LC_W-1:0]   lc_c;
  logic [31:0]       lc_w;
  logic              lc_zero, lc_lt_fill, lc_full, lc_ge_spr, lc_le_al;
  logic              dry_c;
  logic              spr_req_c, drp_req_c;

  inlet_t          in_q, in_d;
  irr_t            ir_q, ir_d;
  logic [TM_W-1:0] tmr_q, tmr_d;

  logic            ve_q, bs_q, vs_q, al_q, e_q;
  logic [LC_W-1:0] lc_q;
  logic            al_d;

  assign raw = {bus.level, bus.Us, bus.Ua, bus.T};

  // Per-bit debounce: count consecutive disagreeing samples, adopt the raw
  // value on the sample that brings the count to DEBOUNCE.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        if (cnt_q[i] + DB_W'(1) == DB_MAX) begin
          filt_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_q <= FILT_RST;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Level decode and demand (all from the filtered values)
  // ---------------------------------------------------------------------
  assign lvl_f = filt_q[NIN-1:3];
  assign us_f  = filt_q[2];
  assign ua_f  = filt_q[1];
  assign t_f   = filt_q[0];

  assign valid_c = is_thermo(lvl_f);
  assign e_c     = ~valid_c;
  // An invalid code freezes the last good level.
  assign lc_c    = valid_c ? popcount(lvl_f) : lc_q;
  assign lc_w    = 32'(lc_c);

  assign lc_zero    = (lc_c == '0);
  assign lc_lt_fill = (lc_w <  32'(FILL_LO));
  assign lc_full    = (lc_w == 32'(LEVELS));
  assign lc_ge_spr  = (lc_w >= 32'(SPR_MIN_LEVEL));
  assign lc_le_al   = (lc_w <= 32'(ALARM_LEVEL));

  // Dry-run protection: no pumping on a sensor fault or an empty tank.
  assign dry_c     = e_c | lc_zero;
  assign spr_req_c = ~dry_c & ~us_f & (~ua_f | (ua_f & t_f & lc_ge_spr));
  assign drp_req_c = ~dry_c & ~us_f & ua_f & (~t_f | (t_f & ~lc_ge_spr));

  // Inlet FSM next state: hysteresis between FILL_LO and a full tank.
  always_comb begin
    in_d = in_q;
    case (in_q)
      IN_IDLE:  if (lc_lt_fill) in_d = IN_FILL;
      IN_FILL:  if (lc_full)    in_d = IN_IDLE;
      IN_FAULT: in_d = IN_IDLE;
      default:  in_d = IN_IDLE;
    endcase
    if (e_c) begin
      in_d = IN_FAULT;
    end
  end

  // Irrigation FSM next state and on-timer: min on-time, fault exit, GAP.
  always_comb begin
    ir_d  = ir_q;
    tmr_d = tmr_q;
    case (ir_q)
      IR_OFF: begin
        if (spr_req_c) begin
          ir_d  = IR_SPRINKLE;
          tmr_d = '0;
        end else if (drp_req_c) begin
          ir_d  = IR_DRIP;
          tmr_d = '0;
        end
      end
      IR_SPRINKLE: begin
        if (dry_c) begin
          ir_d = IR_GAP;
        end else if (!spr_req_c && tmr_q == TMR_MAX) begin
          ir_d = IR_GAP;
        end else if (tmr_q != TMR_MAX) begin
          tmr_d = tmr_q + TM_W'(1);
        end
      end
      IR_DRIP: begin
        if (dry_c) begin
          ir_d = IR_GAP;
        end else if (!drp_req_c && tmr_q == TMR_MAX) begin
          ir_d = IR_GAP;
        end else if (tmr_q != TMR_MAX) begin
          tmr_d = tmr_q + TM_W'(1);
        end
      end
      IR_GAP:  ir_d = IR_OFF;
      default: ir_d = IR_OFF;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q  <= IN_IDLE;
      ir_q  <= IR_OFF;
      tmr_q <= '0;
    end else begin
      in_q  <= in_d;
      ir_q  <= ir_d;
      tmr_q <= tmr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Alarm
  // ---------------------------------------------------------------------
`ifdef ALARM_BLINK_EN
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_DIV - 1);

  logic            low_c;
  logic            low_q;
  logic [BL_W-1:0] blink_q, blink_d;

  assign low_c = lc_le_al & ~e_c;

  // Blink sequencer: E forces steady on; a new low-level alarm restarts at 1.
  always_comb begin
    al_d    = 1'b0;
    blink_d = '0;
    if (e_c) begin
      al_d = 1'b1;
    end else if (low_c && !low_q) begin
      al_d = 1'b1;
    end else if (low_c) begin
      if (blink_q == BL_MAX) begin
        al_d = ~al_q;
      end else begin
        al_d    = al_q;
        blink_d = blink_q + BL_W'(1);
      end
    end
  end

  // Blink counter and alarm-condition history.
  always_ff @(posedge clock) begin
    if (reset) begin
      low_q   <= 1'b0;
      blink_q <= '0;
    end else begin
      low_q   <= low_c;
      blink_q <= blink_d;
    end
  end
`else
  assign al_d = e_c | lc_le_al;
`endif

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ve_q <= 1'b0;
      bs_q <= 1'b0;
      vs_q <= 1'b0;
      al_q <= 1'b0;
      e_q  <= 1'b0;
      lc_q <= '0;
    end else begin
      ve_q <= (in_d == IN_FILL);
      bs_q <= (ir_d == IR_SPRINKLE);
      vs_q <= (ir_d == IR_DRIP);
      al_q <= al_d;
      e_q  <= e_c;
      lc_q <= lc_c;
    end
  end

  assign bus.Ve          = ve_q;
  assign bus.Bs          = bs_q;
  assign bus.Vs          = vs_q;
  assign bus.Al          = al_q;
  assign bus.E           = e_q;
  assign bus.working     = ~e_q;
  assign bus.level_count = lc_q;

endmodule
